// File: rtl/serial_master.sv
`default_nettype none
// ============================================================================
// Module   : serial_master
// Purpose  : SPI-style initiator producing the 40-bit FX2-to-FPGA serial
//            register frame (R/W flag, 7-bit address, 32-bit data, MSB
//            first) from a parallel command, returning read data.
// Revision : 1.0 - initial release
// ============================================================================
module serial_master #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        read_i,
  input  logic [6:0]  addr_i,
  input  logic [31:0] data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        sclk_o,
  output logic        sdi_o,
  output logic        sen_o,
  input  logic        sdo_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Terminal value of the half-period divider (CLK_DIV cycles per phase).
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_nx;
  logic [7:0]  div_cnt, div_cnt_nx;
  logic [5:0]  bit_cnt, bit_cnt_nx;
  logic [39:0] shreg, shreg_nx;
  logic        is_read, is_read_nx;
  logic [31:0] rx_sr, rx_sr_nx;
  logic [31:0] rdata_nx;
  logic        busy_nx, done_nx, sclk_nx, sdi_nx, sen_nx;
  logic        div_done;

  assign div_done = (div_cnt == DIV_LAST);

  // State and all outputs are registered so the serial pins are glitch-free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      is_read <= 1'b0;
      rx_sr   <= '0;
      rdata_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sclk_o  <= 1'b0;
      sdi_o   <= 1'b0;
      sen_o   <= 1'b1;
    end else begin
      state   <= state_nx;
      div_cnt <= div_cnt_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      is_read <= is_read_nx;
      rx_sr   <= rx_sr_nx;
      rdata_o <= rdata_nx;
      busy_o  <= busy_nx;
      done_o  <= done_nx;
      sclk_o  <= sclk_nx;
      sdi_o   <= sdi_nx;
      sen_o   <= sen_nx;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_nx   = state;
    div_cnt_nx = div_cnt;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    is_read_nx = is_read;
    rx_sr_nx   = rx_sr;
    rdata_nx   = rdata_o;
    busy_nx    = busy_o;
    done_nx    = 1'b0;
    sclk_nx    = sclk_o;
    sdi_nx     = sdi_o;
    sen_nx     = sen_o;

    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        sen_nx  = 1'b1;
        sclk_nx = 1'b0;
        sdi_nx  = 1'b0;
        if (start_i) begin
          // Read frames carry zeros in the data field so SDI stays low there.
          shreg_nx   = {read_i, addr_i, (read_i ? 32'h0 : data_i)};
          is_read_nx = read_i;
          bit_cnt_nx = 6'd39;
          div_cnt_nx = '0;
          busy_nx    = 1'b1;
          sen_nx     = 1'b0;
          sdi_nx     = read_i;
          state_nx   = LOW;
        end
      end

      LOW: begin
        if (div_done) begin
          div_cnt_nx = '0;
          sclk_nx    = 1'b1;
          // Responder data is valid on the rising edge of the data field.
          if (is_read && (bit_cnt <= 6'd31)) begin
            rx_sr_nx = {rx_sr[30:0], sdo_i};
          end
          state_nx = HIGH;
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end

      HIGH: begin
        if (div_done) begin
          div_cnt_nx = '0;
          sclk_nx    = 1'b0;
          if (bit_cnt != 6'd0) begin
            bit_cnt_nx = bit_cnt - 6'd1;
            sdi_nx     = shreg[38];
            shreg_nx   = {shreg[38:0], 1'b0};
            state_nx   = LOW;
          end else begin
            sdi_nx   = 1'b0;
            state_nx = HOLD;
          end
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end

      HOLD: begin
        if (div_done) begin
          div_cnt_nx = '0;
          sen_nx     = 1'b1;
          busy_nx    = 1'b0;
          done_nx    = 1'b1;
          sdi_nx     = 1'b0;
          if (is_read) begin
            rdata_nx = rx_sr;
          end
          state_nx = IDLE;
        end else begin
          div_cnt_nx = div_cnt + 8'd1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
